adc_spi_reader: RTL and testbench

ADC_SPI_READER -- requirements
Module: adc_spi_reader

---
 rtl/adc_spi_pkg.sv | 12 +
 rtl/adc_spi_clkgen.sv | 32 +++
 rtl/adc_spi_reader.sv | 96 +++++++++
 tb/tb_adc_spi_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared FSM state encoding and frame constants for the ADC SPI reader
package adc_spi_pkg;
    localparam int CONV_BITS = 16;
    localparam int DATA_BITS = 12;
    localparam int LEAD_BITS = 4;

    typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, QUIET} adc_state_e;

    function automatic logic lead_err(input logic [CONV_BITS-1:0] frame);
        return |frame[CONV_BITS-1 -: LEAD_BITS];
    endfunction
endpackage

// File: rtl/adc_spi_clkgen.sv
// adc_spi_clkgen: SCLK generator, idle high, low-then-high halves of CLK_DIV cycles
module adc_spi_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic en,
    output logic sclk,
    output logic rise
);
    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;

    // asserted in the cycle whose closing edge takes sclk from low to high
    assign rise = en && cnt_q == '0 && !sclk;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
            sclk  <= 1'b1;
        end else if (!en) begin
            cnt_q <= '0;
            sclk  <= 1'b1;
        end else if (cnt_q == '0) begin
            cnt_q <= RELOAD;
            sclk  <= !sclk;
        end else begin
            cnt_q <= cnt_q - 8'd1;
        end
    end
endmodule

// File: rtl/adc_spi_reader.sv
// adc_spi_reader: SPI master reading 16-bit ADC frames and returning the low 12 bits.
// Define ADC_SPI_LEADZERO_CHECK_EN to flag frames whose four leading bits are non-zero.
module adc_spi_reader
    import adc_spi_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int QUIET_CYCLES = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 adc_data_req_i,
    output logic                 adc_data_rdy_o,
    output logic [DATA_BITS-1:0] adc_data_o,
    output logic                 adc_data_err_o,
    output logic                 busy_o,
    output logic                 spi_cs_n_o,
    output logic                 spi_sclk_o,
    input  logic                 spi_miso_i
);
    localparam int CNT_W = 14;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(2 * CONV_BITS * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);
    // Without the lead-zero check only the data bits of the frame need keeping.
`ifdef ADC_SPI_LEADZERO_CHECK_EN
    localparam int FRAME_W = CONV_BITS;
`else
    localparam int FRAME_W = DATA_BITS;
`endif

    adc_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [FRAME_W-1:0]   frame_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 cs_n_q, rdy_q, conv_done, shift_en, sclk_rise;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (adc_data_req_i) state_d = CS_SETUP;
            CS_SETUP: if (cnt_q == SETUP_LAST) state_d = SHIFT;
            SHIFT:    if (cnt_q == SHIFT_LAST) state_d = QUIET;
            QUIET:    if (cnt_q == QUIET_LAST) state_d = adc_data_req_i ? CS_SETUP : IDLE;
            default:  state_d = IDLE;
        endcase
        conv_done = state_q == SHIFT && state_d == QUIET;
        shift_en  = state_d == SHIFT;
    end

    adc_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en        (shift_en),
        .sclk      (spi_sclk_o),
        .rise      (sclk_rise)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q   <= '0;
            cs_n_q  <= 1'b1;
            rdy_q   <= 1'b0;
            frame_q <= '0;
            data_q  <= '0;
        end else begin
            cnt_q  <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
            cs_n_q <= !(state_d == CS_SETUP || state_d == SHIFT);
            rdy_q  <= conv_done;
            if (sclk_rise) frame_q <= {frame_q[FRAME_W-2:0], spi_miso_i};
            if (conv_done) data_q  <= frame_q[DATA_BITS-1:0];
        end
    end

`ifdef ADC_SPI_LEADZERO_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)     err_q <= 1'b0;
        else if (conv_done) err_q <= lead_err(frame_q);
    end

    assign adc_data_err_o = err_q;
`else
    assign adc_data_err_o = 1'b0;
`endif

    assign adc_data_rdy_o = rdy_q;
    assign adc_data_o     = data_q;
    assign spi_cs_n_o     = cs_n_q;
    assign busy_o         = state_q != IDLE;
endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader: two reader configurations (4/4 and 2/1) against a timing model and ADC model
module tb_adc_spi_reader;
`ifdef ADC_SPI_LEADZERO_CHECK_EN
    localparam logic LZ = 1'b1;
`else
    localparam logic LZ = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic reset_n = 1'b0;
    logic req = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [15:0] words [1024];

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int D = g == 0 ? 4 : 2;
        localparam int Q = g == 0 ? 4 : 1;
        localparam int T = 33 * D;

        logic cs_n, sclk, miso, rdy, err, busy;
        logic [11:0] data;

        adc_spi_reader #(.CLK_DIV(D), .QUIET_CYCLES(Q)) dut (
            .clk_i          (clk_i),
            .reset_n_i      (reset_n),
            .adc_data_req_i (req),
            .adc_data_rdy_o (rdy),
            .adc_data_o     (data),
            .adc_data_err_o (err),
            .busy_o         (busy),
            .spi_cs_n_o     (cs_n),
            .spi_sclk_o     (sclk),
            .spi_miso_i     (miso)
        );

        // ADC: next word per conversion, one bit per SCLK falling edge, MSB first
        logic [15:0] aw = '0;
        int abit = -1;
        int aidx = 0;
        initial miso = 1'b0;
        always @(negedge cs_n) if (reset_n) begin
            aw = words[aidx];
            aidx++;
            abit = 15;
        end
        always @(negedge sclk) if (!cs_n && abit >= 0) begin
            miso = aw[abit];
            abit--;
        end

        // Model: S = start cycle of the latest conversion, E = earliest edge allowed to start one
        int cyc = 0;
        int S = -100000;
        int E = 0;
        int midx = 0;
        logic [15:0] mw = '0;
        logic [11:0] exp_data = '0;
        logic exp_err = 1'b0;
        always @(posedge clk_i or negedge reset_n) begin
            if (!reset_n) begin
                S = -100000;
                E = 0;
                exp_data = '0;
                exp_err = 1'b0;
            end else begin
                cyc++;
                if (cyc == S + T) begin
                    exp_data = mw[11:0];
                    exp_err = LZ & (|mw[15:12]);
                end
                if (cyc >= E && req) begin
                    S = cyc;
                    E = cyc + T + Q;
                    mw = words[midx];
                    midx++;
                end
            end
        end

        int rdy_cnt = 0;
        int cs_run = 0;
        int cs_len = 0;
        int rdy_at[$];
        logic [11:0] rdy_dat[$];
        logic rdy_er[$];
        always @(negedge clk_i) begin : cmp
            int k;
            k = cyc - S - D;
            if (!reset_n) cs_run = 0;
            else begin
                chk($sformatf("u%0d.cs_n", g), 32'(cs_n), 32'(!(cyc >= S && cyc < S + T)));
                chk($sformatf("u%0d.sclk", g), 32'(sclk), 32'((k >= 0 && k < 32 * D) ? (k / D) % 2 : 1));
                chk($sformatf("u%0d.busy", g), 32'(busy), 32'(cyc >= S && cyc < S + T + Q));
                chk($sformatf("u%0d.rdy", g), 32'(rdy), 32'(cyc == S + T));
                chk($sformatf("u%0d.data", g), 32'(data), 32'(exp_data));
                chk($sformatf("u%0d.err", g), 32'(err), 32'(exp_err));
                if (rdy) begin
                    rdy_cnt++;
                    rdy_at.push_back(cyc);
                    rdy_dat.push_back(data);
                    rdy_er.push_back(err);
                end
                if (!cs_n) cs_run++;
                else if (cs_run > 0) begin
                    cs_len = cs_run;
                    cs_run = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((u[0].busy || u[1].busy) && n < 3000) begin
            tick(1);
            n++;
        end
        chk(nm, 32'(u[0].busy | u[1].busy), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b0, b1, n, m;
        for (int i = 0; i < 1024; i++)
            words[i] = ($urandom % 2 == 0) ? 16'($urandom) : 16'($urandom & 32'h0FFF);
        words[0] = 16'h0ABC;
        words[1] = 16'h0001;
        words[2] = 16'h0FFF;
        words[3] = 16'h0800;
        words[4] = 16'h8123;
        words[5] = 16'h0123;

        tick(3);
        chk("rst.u0", 32'({u[0].cs_n, u[0].sclk, u[0].rdy, u[0].err, u[0].busy, u[0].data}), 32'h18000);
        chk("rst.u1", 32'({u[1].cs_n, u[1].sclk, u[1].rdy, u[1].err, u[1].busy, u[1].data}), 32'h18000);
        reset_n = 1'b1;
        tick(5);

        // single-cycle request, frame 0x0ABC
        b0 = u[0].rdy_cnt;
        req = 1'b1;
        tick(1);
        req = 1'b0;
        wait_idle("s1.idle");
        chk("s1.rdy_count", 32'(u[0].rdy_cnt - b0), 32'd1);
        chk("s1.data", 32'(u[0].rdy_dat[$]), 32'h0ABC);
        chk("s1.err", 32'(u[0].rdy_er[$]), 32'd0);
        chk("s1.cs_len", 32'(u[0].cs_len), 32'd132);
        chk("s1.cs_len_div2", 32'(u[1].cs_len), 32'd66);
        chk("s1.data_div2", 32'(u[1].rdy_dat[$]), 32'h0ABC);

        // request held for three back-to-back conversions
        b0 = u[0].rdy_cnt;
        req = 1'b1;
        n = 0;
        while (u[0].rdy_cnt < b0 + 2 && n < 1000) begin
            tick(1);
            n++;
        end
        chk("s2.bound", 32'(n < 1000), 32'd1);
        tick(10);
        req = 1'b0;
        wait_idle("s2.idle");
        chk("s2.rdy_count", 32'(u[0].rdy_cnt - b0), 32'd3);
        chk("s2.gap1", 32'(u[0].rdy_at[b0 + 1] - u[0].rdy_at[b0]), 32'd136);
        chk("s2.gap2", 32'(u[0].rdy_at[b0 + 2] - u[0].rdy_at[b0 + 1]), 32'd136);
        chk("s2.data0", 32'(u[0].rdy_dat[b0]), 32'h001);
        chk("s2.data1", 32'(u[0].rdy_dat[b0 + 1]), 32'hFFF);
        chk("s2.data2", 32'(u[0].rdy_dat[b0 + 2]), 32'h800);
        m = u[1].rdy_at.size();
        chk("s2.gap_div2", 32'(u[1].rdy_at[m - 1] - u[1].rdy_at[m - 2]), 32'd67);

        // request dropped 20 cycles into the conversion, frame 0x8123
        b0 = u[0].rdy_cnt;
        req = 1'b1;
        tick(20);
        req = 1'b0;
        wait_idle("s3.idle");
        chk("s3.rdy_count", 32'(u[0].rdy_cnt - b0), 32'd1);
        chk("s3.data", 32'(u[0].rdy_dat[$]), 32'h123);
        chk("s3.err", 32'(u[0].rdy_er[$]), 32'(LZ));
        chk("s3.busy", 32'(u[0].busy), 32'd0);

        // clean frame 0x0123 clears the flag
        req = 1'b1;
        tick(1);
        req = 1'b0;
        wait_idle("s4.idle");
        chk("s4.data", 32'(u[0].rdy_dat[$]), 32'h123);
        chk("s4.err", 32'(u[0].rdy_er[$]), 32'd0);

        // random request traffic
        repeat (40) begin
            req = 1'($urandom % 2);
            tick($urandom_range(1, 300));
        end
        req = 1'b0;
        wait_idle("rnd.idle");

        // reset at cycle 60 of a conversion
        b0 = u[0].rdy_cnt;
        b1 = u[1].rdy_cnt;
        req = 1'b1;
        tick(1);
        req = 1'b0;
        chk("s5.cs_low", 32'(u[0].cs_n), 32'd0);
        tick(60);
        reset_n = 1'b0;
        #1;
        chk("s5.rst.u0", 32'({u[0].cs_n, u[0].sclk, u[0].rdy, u[0].err, u[0].busy, u[0].data}), 32'h18000);
        chk("s5.rst.u1", 32'({u[1].cs_n, u[1].sclk, u[1].rdy, u[1].err, u[1].busy, u[1].data}), 32'h18000);
        tick(3);
        reset_n = 1'b1;
        tick(40);
        chk("s5.no_rdy", 32'(u[0].rdy_cnt - b0), 32'd0);
        chk("s5.no_rdy_div2", 32'(u[1].rdy_cnt - b1), 32'd0);
        chk("s5.idle_cs", 32'({u[0].cs_n, u[1].cs_n}), 32'd3);

        // recovery conversion after reset
        req = 1'b1;
        tick(1);
        req = 1'b0;
        wait_idle("s6.idle");
        chk("s6.rdy_count", 32'(u[0].rdy_cnt - b0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
